// File: rtl/updn_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : updn_counter_pkg
// Purpose  : Shared definitions for the up/down modulo counter: end-of-range
//            mode encodings, FSM state type and the step/limit clamp helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package updn_counter_pkg;

    // End-of-range behaviour; 2'b11 is decoded as wrap by the datapath.
    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // Returns min(value, limit). Operands are carried at 32 bits so one
    // function serves every WIDTH up to 32; callers zero-extend and truncate.
    function automatic logic [31:0] clamp_step(input logic [31:0] value,
                                               input logic [31:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/updn_next_calc.sv
`default_nettype none
// ============================================================================
// Module   : updn_next_calc
// Purpose  : Combinational next-count datapath. Given the current count, an
//            already-clamped step and the limit, produces the next count,
//            an out-of-range event flag and a one-shot terminal flag.
// Ports    : i_count      - current count register value
//            i_step       - effective step (already <= i_limit)
//            i_limit      - upper bound of legal range 0..i_limit
//            i_dir        - 1 = up, 0 = down
//            i_mode       - end-of-range mode
//            o_next_count - count to load if the counter advances
//            o_event      - an out-of-range branch was taken
//            o_terminal   - one-shot end reached (enter DONE)
// Revision : 1.0 - initial release
// ============================================================================
module updn_next_calc
    import updn_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_step,
    input  logic [WIDTH-1:0] i_limit,
    input  logic             i_dir,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_next_count,
    output logic             o_event,
    output logic             o_terminal
);

    localparam logic [WIDTH:0] c_one = {{WIDTH{1'b0}}, 1'b1};

    // One extra bit so count + step and count + limit + 1 never overflow.
    logic [WIDTH:0] w_cnt;
    logic [WIDTH:0] w_s;
    logic [WIDTH:0] w_lim;
    logic [WIDTH:0] w_sum;

    assign w_cnt = {1'b0, i_count};
    assign w_s   = {1'b0, i_step};
    assign w_lim = {1'b0, i_limit};
    assign w_sum = w_cnt + w_s;

    always_comb begin
        o_next_count = i_count;
        o_event      = 1'b0;
        o_terminal   = 1'b0;

        if (i_count > i_limit) begin
            // Limit was lowered underneath the count: snap back into range
            // regardless of mode or step.
            o_next_count = i_limit;
            o_event      = 1'b1;
        end else if (i_dir) begin
            if (w_sum <= w_lim) begin
                o_next_count = WIDTH'(w_sum);
            end else begin
                o_event = 1'b1;
                case (i_mode)
                    MODE_SAT: begin
                        o_next_count = i_limit;
                    end
                    MODE_ONESHOT: begin
                        o_next_count = i_limit;
                        o_terminal   = 1'b1;
                    end
                    default: begin
                        // step <= limit and count <= limit, so this lands in
                        // 0..limit-1 without a second wrap.
                        o_next_count = WIDTH'(w_sum - (w_lim + c_one));
                    end
                endcase
            end
        end else begin
            if (w_s <= w_cnt) begin
                o_next_count = WIDTH'(w_cnt - w_s);
            end else begin
                o_event = 1'b1;
                case (i_mode)
                    MODE_SAT: begin
                        o_next_count = '0;
                    end
                    MODE_ONESHOT: begin
                        o_next_count = '0;
                        o_terminal   = 1'b1;
                    end
                    default: begin
                        o_next_count = WIDTH'(w_cnt + w_lim + c_one - w_s);
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/updn_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : updn_mod_counter
// Purpose  : Parametrised up/down counter with programmable modulo limit,
//            variable step and wrap / saturate / one-shot end-of-range modes.
// Ports    : clk, rst    - clock, synchronous active-high reset
//            en, dir     - count enable, direction (1 = up)
//            step        - step magnitude (clamped to limit)
//            limit       - upper bound of the count range
//            mode        - 00 wrap, 01 saturate, 10 one-shot, 11 wrap
//            load        - preset strobe, load_value clamped to limit
//            pause       - freeze count and FSM
//            count       - registered count
//            at_zero     - count == 0
//            at_max      - count == limit
//            wrap_pulse  - registered one-cycle out-of-range strobe
//            done        - registered sticky one-shot completion flag
// Revision : 1.0 - initial release
// ============================================================================
module updn_mod_counter
    import updn_counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic [1:0]        mode,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic              pause,
    output logic [WIDTH-1:0]  count,
    output logic              at_zero,
    output logic              at_max,
    output logic              wrap_pulse,
    output logic              done
);

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;
    logic             r_wrap_q;
    logic             w_wrap_d;
    logic             r_done_q;
    logic             w_done_d;
    state_t           r_state_q;
    state_t           w_state_d;

    logic [WIDTH-1:0] w_step_eff;
    logic [WIDTH-1:0] w_load_eff;
    logic [WIDTH-1:0] w_next_count;
    logic             w_event;
    logic             w_terminal;

    assign w_step_eff = WIDTH'(clamp_step(32'(step), 32'(limit)));
    assign w_load_eff = WIDTH'(clamp_step(32'(load_value), 32'(limit)));

    updn_next_calc #(
        .WIDTH (WIDTH)
    ) u_next_calc (
        .i_count      (r_count_q),
        .i_step       (w_step_eff),
        .i_limit      (limit),
        .i_dir        (dir),
        .i_mode       (mode),
        .o_next_count (w_next_count),
        .o_event      (w_event),
        .o_terminal   (w_terminal)
    );

    // Priority below reset: load > pause > DONE hold > enabled count > hold.
    always_comb begin
        w_count_d = r_count_q;
        w_wrap_d  = 1'b0;
        w_done_d  = r_done_q;
        w_state_d = r_state_q;

        if (load) begin
            w_count_d = w_load_eff;
            w_done_d  = 1'b0;
            w_state_d = ST_RUN;
        end else if (pause) begin
            // hold everything; strobe stays low
        end else if (r_state_q == ST_DONE) begin
            // one-shot finished: only load leaves this state
        end else if (en) begin
            w_count_d = w_next_count;
            w_wrap_d  = w_event;
            if (w_terminal) begin
                w_done_d  = 1'b1;
                w_state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
            r_wrap_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_state_q <= ST_RUN;
        end else begin
            r_count_q <= w_count_d;
            r_wrap_q  <= w_wrap_d;
            r_done_q  <= w_done_d;
            r_state_q <= w_state_d;
        end
    end

    assign count      = r_count_q;
    assign wrap_pulse = r_wrap_q;
    assign done       = r_done_q;
    assign at_zero    = (r_count_q == '0);
    assign at_max     = (r_count_q == limit);

endmodule
`default_nettype wire

// File: tb/tb_updn_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_updn_mod_counter
// Purpose  : Directed self-checking bench for updn_mod_counter (WIDTH = 8,
//            STEP_W = 4) with hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_updn_mod_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       dir;
    logic [3:0] step;
    logic [7:0] limit;
    logic [1:0] mode;
    logic       load;
    logic [7:0] load_value;
    logic       pause;
    logic [7:0] count;
    logic       at_zero;
    logic       at_max;
    logic       wrap_pulse;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    updn_mod_counter #(
        .WIDTH  (8),
        .STEP_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dir        (dir),
        .step       (step),
        .limit      (limit),
        .mode       (mode),
        .load       (load),
        .load_value (load_value),
        .pause      (pause),
        .count      (count),
        .at_zero    (at_zero),
        .at_max     (at_max),
        .wrap_pulse (wrap_pulse),
        .done       (done)
    );

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [7:0] lim, input logic [7:0] val);
        limit = lim; load_value = val; load = 1'b1; en = 1'b0; pause = 1'b0;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; load_value = 8'd77; limit = 8'd100; en = 1'b1;
        dir = 1'b1; step = 4'd1; mode = 2'b00; pause = 1'b0;
        tick(); tick();
        n_vec++;
        if ({count, done, wrap_pulse, at_zero, at_max} !== {8'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset: count=%0d done=%b pulse=%b at_zero=%b at_max=%b, want 0 0 0 1 0",
                     count, done, wrap_pulse, at_zero, at_max);
        end
        rst = 1'b0; en = 1'b0; load_value = 8'd200; limit = 8'd150;
        tick();
        load = 1'b0;
        n_vec++;
        if ({count, at_max, wrap_pulse} !== {8'd150, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL load_clamp: count=%0d at_max=%b pulse=%b, want 150 1 0", count, at_max, wrap_pulse);
        end
    endtask

    task automatic test_wrap_up();
        preset(8'd9, 8'd7);
        en = 1'b1; dir = 1'b1; step = 4'd3; mode = 2'b00;
        tick();
        n_vec++;
        if ({count, wrap_pulse} !== {8'd0, 1'b1}) begin
            n_err++;
            $display("FAIL wrap_up_event: count=%0d pulse=%b, want 0 1", count, wrap_pulse);
        end
        tick();
        n_vec++;
        if ({count, wrap_pulse} !== {8'd3, 1'b0}) begin
            n_err++;
            $display("FAIL wrap_up_next: count=%0d pulse=%b, want 3 0", count, wrap_pulse);
        end
    endtask

    task automatic test_wrap_down_sat();
        preset(8'd9, 8'd1);
        en = 1'b1; dir = 1'b0; step = 4'd4; mode = 2'b11;   // 11 behaves as wrap
        tick();
        n_vec++;
        if ({count, wrap_pulse} !== {8'd7, 1'b1}) begin
            n_err++;
            $display("FAIL wrap_down: count=%0d pulse=%b, want 7 1", count, wrap_pulse);
        end
        preset(8'd9, 8'd1);
        en = 1'b1; mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({count, wrap_pulse, at_zero} !== {8'd0, 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL sat_down_%0d: count=%0d pulse=%b at_zero=%b, want 0 1 1",
                         i, count, wrap_pulse, at_zero);
            end
        end
        // Saturate up at limit: back-to-back pulses every enabled cycle.
        preset(8'd9, 8'd9);
        en = 1'b1; dir = 1'b1; step = 4'd1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if ({count, wrap_pulse} !== {8'd9, 1'b1}) begin
                n_err++;
                $display("FAIL sat_up_b2b_%0d: count=%0d pulse=%b, want 9 1", i, count, wrap_pulse);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [7:0] exp_cnt [3] = '{8'd2, 8'd4, 8'd5};
        logic       exp_pls [3] = '{1'b0, 1'b0, 1'b1};
        preset(8'd5, 8'd0);
        en = 1'b1; dir = 1'b1; step = 4'd2; mode = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({count, wrap_pulse, done} !== {exp_cnt[i], exp_pls[i], exp_pls[i]}) begin
                n_err++;
                $display("FAIL oneshot_run_%0d: count=%0d pulse=%b done=%b, want %0d %b %b",
                         i, count, wrap_pulse, done, exp_cnt[i], exp_pls[i], exp_pls[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) dir = 1'b0;
            if (i == 3) mode = 2'b00;      // mode change must not leave DONE
            tick();
            n_vec++;
            if ({count, wrap_pulse, done} !== {8'd5, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL oneshot_hold_%0d: count=%0d pulse=%b done=%b, want 5 0 1",
                         i, count, wrap_pulse, done);
            end
        end
        mode = 2'b10; dir = 1'b1; load_value = 8'd0; load = 1'b1;
        tick();
        load = 1'b0;
        n_vec++;
        if ({count, done} !== {8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL oneshot_reload: count=%0d done=%b, want 0 0", count, done);
        end
        tick();
        n_vec++;
        if ({count, wrap_pulse, done} !== {8'd2, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL oneshot_resume: count=%0d pulse=%b done=%b, want 2 0 0", count, wrap_pulse, done);
        end
        // Run to DONE again, then reset mid-state.
        tick(); tick();
        rst = 1'b1; load = 1'b1; pause = 1'b1; load_value = 8'd3;
        tick();
        rst = 1'b0; load = 1'b0; pause = 1'b0;
        n_vec++;
        if ({count, done, wrap_pulse} !== {8'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_in_done: count=%0d done=%b pulse=%b, want 0 0 0", count, done, wrap_pulse);
        end
    endtask

    task automatic test_priority_pause();
        preset(8'd200, 8'd120);
        en = 1'b1; dir = 1'b1; step = 4'd1; mode = 2'b00; pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({count, wrap_pulse} !== {8'd120, 1'b0}) begin
                n_err++;
                $display("FAIL pause_%0d: count=%0d pulse=%b, want 120 0", i, count, wrap_pulse);
            end
        end
        load = 1'b1; load_value = 8'd10;
        tick();
        load = 1'b0; pause = 1'b0;
        n_vec++;
        if (count !== 8'd10) begin
            n_err++;
            $display("FAIL load_over_pause: count=%0d, want 10", count);
        end
        preset(8'd200, 8'd120);
        limit = 8'd120;
        #1;
        n_vec++;
        if (at_max !== 1'b1) begin
            n_err++;
            $display("FAIL at_max_comb: at_max=%b, want 1", at_max);
        end
        limit = 8'd50; en = 1'b0;
        tick();
        n_vec++;
        if ({count, wrap_pulse, at_max} !== {8'd120, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL range_disabled: count=%0d pulse=%b at_max=%b, want 120 0 0", count, wrap_pulse, at_max);
        end
        en = 1'b1; dir = 1'b0;
        tick();
        n_vec++;
        if ({count, wrap_pulse, at_max} !== {8'd50, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL range_snap: count=%0d pulse=%b at_max=%b, want 50 1 1", count, wrap_pulse, at_max);
        end
    endtask

    task automatic test_edges();
        preset(8'd9, 8'd5);
        en = 1'b1; dir = 1'b1; step = 4'd0; mode = 2'b01;
        tick();
        n_vec++;
        if ({count, wrap_pulse} !== {8'd5, 1'b0}) begin
            n_err++;
            $display("FAIL step_zero: count=%0d pulse=%b, want 5 0", count, wrap_pulse);
        end
        preset(8'd3, 8'd0);
        en = 1'b1; dir = 1'b1; step = 4'd15; mode = 2'b00;
        tick();
        n_vec++;
        if ({count, wrap_pulse, at_max} !== {8'd3, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL step_clamp_land: count=%0d pulse=%b at_max=%b, want 3 0 1", count, wrap_pulse, at_max);
        end
        tick();
        n_vec++;
        if ({count, wrap_pulse} !== {8'd2, 1'b1}) begin
            n_err++;
            $display("FAIL step_clamp_wrap: count=%0d pulse=%b, want 2 1", count, wrap_pulse);
        end
        preset(8'd0, 8'd33);
        en = 1'b1; step = 4'd5;
        for (int i = 0; i < 2; i++) begin
            dir = (i == 0);
            tick();
            n_vec++;
            if ({count, wrap_pulse, at_zero, at_max} !== {8'd0, 1'b0, 1'b1, 1'b1}) begin
                n_err++;
                $display("FAIL limit_zero_%0d: count=%0d pulse=%b at_zero=%b at_max=%b, want 0 0 1 1",
                         i, count, wrap_pulse, at_zero, at_max);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down_sat();
        test_oneshot();
        test_priority_pause();
        test_edges();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
